// File: rtl/hsk_chk_pkg.sv
// Shared types and helpers for the start/ready/busy handshake window checker.
package hsk_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUSY = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_EARLY   = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_SHORT   = 3'd3,
        ERR_LONG    = 3'd4,
        ERR_OVERLAP = 3'd5
    } err_e;

    // Width of the per-channel k/b counters; the +2 leaves headroom past the larger limit.
    function automatic int cnt_width(input int lat_max, input int busy_max);
        int m;
        m = (lat_max > busy_max) ? lat_max : busy_max;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/hsk_chk_channel.sv
// One handshake channel: IDLE/WAIT/BUSY FSM with latency and busy-length counters.
// Optional concurrent assertions are compiled when HSK_CHK_SVA_EN is defined.
module hsk_chk_channel
    import hsk_chk_pkg::*;
#(
    parameter int LAT_MIN  = 2,
    parameter int LAT_MAX  = 4,
    parameter int BUSY_MIN = 2,
    parameter int BUSY_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clr_err,
    input  logic       start,
    input  logic       ready,
    input  logic       busy,
    output logic       active,
    output logic       pass_pulse,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic       err_sticky,
    output logic       err_now
);

    localparam int CW = cnt_width(LAT_MAX, BUSY_MAX);

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] b_q, b_d;
    err_e          err_d;
    logic          pass_d;
    err_e          code_q;
    logic          sticky_q;
    logic          pass_q;
    logic          err_q;

    // Overlap is checked before the per-state rules so it always wins.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        b_d     = b_q;
        err_d   = ERR_NONE;
        pass_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            k_d     = '0;
            b_d     = '0;
        end else if (start && (state_q != IDLE)) begin
            err_d   = ERR_OVERLAP;
            state_d = WAIT;
            k_d     = CW'(1);
            b_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WAIT;
                        k_d     = CW'(1);
                    end
                end
                WAIT: begin
                    if (ready) begin
                        if (k_q < CW'(LAT_MIN)) begin
                            err_d   = ERR_EARLY;
                            state_d = IDLE;
                        end else begin
                            state_d = BUSY;
                            b_d     = '0;
                        end
                    end else if (k_q == CW'(LAT_MAX)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
                BUSY: begin
                    // b == BUSY_MAX with busy still high means this is sample BUSY_MAX+1.
                    if (busy) begin
                        if (b_q == CW'(BUSY_MAX)) begin
                            err_d   = ERR_LONG;
                            state_d = IDLE;
                        end else begin
                            b_d = b_q + CW'(1);
                        end
                    end else if (b_q < CW'(BUSY_MIN)) begin
                        err_d   = ERR_SHORT;
                        state_d = IDLE;
                    end else begin
                        pass_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign err_now = (err_d != ERR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            b_q     <= b_d;
        end
    end

    // A fresh error outranks a concurrent clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            sticky_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
            err_q  <= err_now;
            if (err_now) begin
                code_q   <= err_d;
                sticky_q <= 1'b1;
            end else if (clr_err) begin
                code_q   <= ERR_NONE;
                sticky_q <= 1'b0;
            end
        end
    end

    assign active     = (state_q != IDLE);
    assign pass_pulse = pass_q;
    assign err_pulse  = err_q;
    assign err_code   = code_q;
    assign err_sticky = sticky_q;

`ifdef HSK_CHK_SVA_EN
    a_no_early: assert property (@(posedge clk) disable iff (rst || !enable)
        (state_q == WAIT && !start && k_q < CW'(LAT_MIN)) |-> !ready)
        else $error("%m: handshake error code %0d", ERR_EARLY);

    a_no_timeout: assert property (@(posedge clk) disable iff (rst || !enable)
        (state_q == WAIT && !start && k_q == CW'(LAT_MAX)) |-> ready)
        else $error("%m: handshake error code %0d", ERR_TIMEOUT);

    a_no_short: assert property (@(posedge clk) disable iff (rst || !enable)
        (state_q == BUSY && !start && !busy) |-> (b_q >= CW'(BUSY_MIN)))
        else $error("%m: handshake error code %0d", ERR_SHORT);

    a_no_long: assert property (@(posedge clk) disable iff (rst || !enable)
        (state_q == BUSY && !start && busy) |-> (b_q != CW'(BUSY_MAX)))
        else $error("%m: handshake error code %0d", ERR_LONG);

    a_no_overlap: assert property (@(posedge clk) disable iff (rst || !enable)
        (state_q != IDLE) |-> !start)
        else $error("%m: handshake error code %0d", ERR_OVERLAP);

    c_pass: cover property (@(posedge clk) disable iff (rst || !enable) pass_d);
`endif

endmodule

// File: rtl/hsk_window_checker.sv
// Multi-channel start/ready/busy window checker with a shared saturating error counter.
// Define HSK_CHK_SVA_EN to add per-channel concurrent assertions; port behaviour is unchanged.
module hsk_window_checker
    import hsk_chk_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int LAT_MIN  = 2,
    parameter int LAT_MAX  = 4,
    parameter int BUSY_MIN = 2,
    parameter int BUSY_MAX = 5,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_err,
    input  logic [NUM_CH-1:0]     start,
    input  logic [NUM_CH-1:0]     ready,
    input  logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     active,
    output logic [NUM_CH-1:0]     pass_pulse,
    output logic [NUM_CH-1:0]     err_pulse,
    output logic [3*NUM_CH-1:0]   err_code,
    output logic [NUM_CH-1:0]     err_sticky,
    output logic [CNT_W-1:0]      err_count
);

    localparam int PCW = $clog2(NUM_CH + 1);
    localparam int SW  = CNT_W + PCW;

    if (LAT_MIN < 1) begin : g_bad_lat_min
        $fatal(1, "hsk_window_checker: LAT_MIN must be >= 1");
    end
    if (LAT_MIN > LAT_MAX) begin : g_bad_lat_order
        $fatal(1, "hsk_window_checker: LAT_MIN must not exceed LAT_MAX");
    end
    if (BUSY_MIN < 1) begin : g_bad_busy_min
        $fatal(1, "hsk_window_checker: BUSY_MIN must be >= 1");
    end
    if (BUSY_MIN > BUSY_MAX) begin : g_bad_busy_order
        $fatal(1, "hsk_window_checker: BUSY_MIN must not exceed BUSY_MAX");
    end

    logic [NUM_CH-1:0] err_now;
    logic [PCW-1:0]    err_pop;
    logic [SW-1:0]     cnt_sum;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hsk_chk_channel #(
            .LAT_MIN  (LAT_MIN),
            .LAT_MAX  (LAT_MAX),
            .BUSY_MIN (BUSY_MIN),
            .BUSY_MAX (BUSY_MAX)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .clr_err    (clr_err),
            .start      (start[i]),
            .ready      (ready[i]),
            .busy       (busy[i]),
            .active     (active[i]),
            .pass_pulse (pass_pulse[i]),
            .err_pulse  (err_pulse[i]),
            .err_code   (err_code[3*i +: 3]),
            .err_sticky (err_sticky[i]),
            .err_now    (err_now[i])
        );
    end

    // A clear restarts the count from this cycle's errors rather than from zero.
    always_comb begin
        err_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            err_pop = err_pop + PCW'(err_now[i]);
        end
        cnt_sum = (clr_err ? '0 : SW'(cnt_q)) + SW'(err_pop);
        if (|cnt_sum[SW-1:CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;

endmodule
